// File: rtl/line_buf_pkg.sv
// ---------------------------------------------------------------------------
// line_buf_pkg
//   Shared constants and helpers for the line window buffer.
//   - Default geometry (pixel width, line length, window width)
//   - ptr_width(): address width for a power-of-two line memory
//   - rd_kind_e: classification of a window read (none / step / last)
// ---------------------------------------------------------------------------
package line_buf_pkg;

  localparam int PIX_W_DEF    = 8;
  localparam int LINE_LEN_DEF = 512;
  localparam int WIN_DEF      = 3;

  // Address bits needed to index a line memory of 'depth' entries.
  // Never returns less than 1 so that degenerate sizes still give a legal
  // vector width.
  function automatic int ptr_width(input int depth);
    if (depth <= 2) begin
      return 1;
    end
    return $clog2(depth);
  endfunction

  // What a window read does to the pointers this cycle.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,  // no read accepted
    RD_STEP = 2'd1,  // interior window: slide by one pixel
    RD_LAST = 2'd2   // last window of the line: drop the whole window
  } rd_kind_e;

endpackage : line_buf_pkg

// File: rtl/line_buf_mem.sv
// ---------------------------------------------------------------------------
// line_buf_mem
//   Pixel storage for one image line. One synchronous write port and WIN
//   combinational read taps at consecutive addresses starting at RD_ADDR.
//   Addresses wrap modulo LINE_LEN (power of two, so the natural AW-bit
//   overflow gives the wrap). Contents are never reset.
//
// Ports
//   CLK      in   clock, write on rising edge
//   WR_EN    in   write strobe
//   WR_ADDR  in   write address           [AW-1:0]
//   WR_DATA  in   write pixel             [PIX_W-1:0]
//   RD_ADDR  in   address of oldest tap   [AW-1:0]
//   RD_DATA  out  WIN pixels, tap 0 (RD_ADDR) in the MSBs [WIN*PIX_W-1:0]
// ---------------------------------------------------------------------------
module line_buf_mem
  import line_buf_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int WIN      = WIN_DEF,
  parameter int AW       = ptr_width(LINE_LEN)
) (
  input  logic                 CLK,
  input  logic                 WR_EN,
  input  logic [AW-1:0]        WR_ADDR,
  input  logic [PIX_W-1:0]     WR_DATA,
  input  logic [AW-1:0]        RD_ADDR,
  output logic [WIN*PIX_W-1:0] RD_DATA
);

  logic [PIX_W-1:0] mem [LINE_LEN];

  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Tap gi reads RD_ADDR+gi; the oldest pixel (gi=0) lands in the top slice.
  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_tap
      logic [AW-1:0] tap_addr;
      assign tap_addr = RD_ADDR + AW'(gi);
      assign RD_DATA[(WIN-gi)*PIX_W-1 -: PIX_W] = mem[tap_addr];
    end
  endgenerate

endmodule : line_buf_mem

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
//   Circular line buffer that presents a sliding horizontal window of WIN
//   pixels. Pixels are written one per cycle; each window read slides the
//   window by one pixel, except the last window of a line, which releases
//   the whole window so the next line starts with a fresh window.
//
// Ports
//   CLK         in   clock
//   RESETH      in   asynchronous active-high reset
//   CLEAR       in   synchronous flush of pointers/count (memory kept)
//   DATA        in   write pixel                      [PIX_W-1:0]
//   DATA_VALID  in   write request
//   DATA_READY  out  space available (!FULL)
//   READ_DATA   in   consume current window
//   DATA_OUT    out  current window, oldest in MSBs   [WIN*PIX_W-1:0]
//   OUT_VALID   out  COUNT >= WIN
//   LINE_DONE   out  one-cycle pulse after the last window read of a line
//   FULL        out  COUNT == LINE_LEN
//   EMPTY       out  COUNT == 0
//   COUNT       out  stored, unreleased pixels        [clog2(LINE_LEN):0]
// ---------------------------------------------------------------------------
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int WIN      = WIN_DEF
) (
  input  logic                           CLK,
  input  logic                           RESETH,
  input  logic                           CLEAR,
  input  logic [PIX_W-1:0]               DATA,
  input  logic                           DATA_VALID,
  output logic                           DATA_READY,
  input  logic                           READ_DATA,
  output logic [WIN*PIX_W-1:0]           DATA_OUT,
  output logic                           OUT_VALID,
  output logic                           LINE_DONE,
  output logic                           FULL,
  output logic                           EMPTY,
  output logic [ptr_width(LINE_LEN):0]   COUNT
);

  localparam int AW = ptr_width(LINE_LEN);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] COL_LAST = AW'(LINE_LEN - WIN);
  localparam logic [AW-1:0] WIN_STEP = AW'(WIN);
  localparam logic [CW-1:0] WIN_CNT  = CW'(WIN);
  localparam logic [CW-1:0] DEPTH    = CW'(LINE_LEN);

  logic [AW-1:0] w_ptr_reg, w_ptr_next;
  logic [AW-1:0] r_ptr_reg, r_ptr_next;
  logic [AW-1:0] col_reg,   col_next;
  logic [CW-1:0] count_reg, count_next;
  logic          line_done_reg, line_done_next;

  logic          full;
  logic          empty;
  logic          out_valid;
  logic          wr_fire;
  logic          rd_fire;
  logic          mem_wr_en;
  logic [CW-1:0] released;
  rd_kind_e      rd_kind;

  // -------------------------------------------------------------------------
  // Status
  // -------------------------------------------------------------------------
  assign full      = (count_reg == DEPTH);
  assign empty     = (count_reg == '0);
  assign out_valid = (count_reg >= WIN_CNT);

  // FULL is judged on the registered count, so a read in the same cycle
  // does not open space for a write at FULL.
  assign wr_fire   = DATA_VALID && !full;
  assign rd_fire   = READ_DATA && out_valid;

  // A flush wins over a same-cycle write, so the pixel is not stored either.
  assign mem_wr_en = wr_fire && !CLEAR;

  // -------------------------------------------------------------------------
  // Read classification
  // -------------------------------------------------------------------------
  always_comb begin
    rd_kind = RD_IDLE;
    if (rd_fire) begin
      rd_kind = (col_reg == COL_LAST) ? RD_LAST : RD_STEP;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_ptr_next     = w_ptr_reg;
    r_ptr_next     = r_ptr_reg;
    col_next       = col_reg;
    line_done_next = 1'b0;
    released       = '0;

    // Pointer wrap is implicit: LINE_LEN is a power of two.
    if (wr_fire) begin
      w_ptr_next = w_ptr_reg + AW'(1);
    end

    case (rd_kind)
      RD_STEP: begin
        r_ptr_next = r_ptr_reg + AW'(1);
        col_next   = col_reg + AW'(1);
        released   = CW'(1);
      end
      RD_LAST: begin
        // The remaining WIN-1 pixels of the line can never form another
        // window, so the whole window is released at once.
        r_ptr_next     = r_ptr_reg + WIN_STEP;
        col_next       = '0;
        released       = WIN_CNT;
        line_done_next = 1'b1;
      end
      default: begin
      end
    endcase

    count_next = count_reg + {{AW{1'b0}}, wr_fire} - released;

    if (CLEAR) begin
      w_ptr_next     = '0;
      r_ptr_next     = '0;
      col_next       = '0;
      count_next     = '0;
      line_done_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESETH) begin
    if (RESETH) begin
      w_ptr_reg     <= '0;
      r_ptr_reg     <= '0;
      col_reg       <= '0;
      count_reg     <= '0;
      line_done_reg <= 1'b0;
    end else begin
      w_ptr_reg     <= w_ptr_next;
      r_ptr_reg     <= r_ptr_next;
      col_reg       <= col_next;
      count_reg     <= count_next;
      line_done_reg <= line_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  line_buf_mem #(
    .PIX_W    (PIX_W),
    .LINE_LEN (LINE_LEN),
    .WIN      (WIN),
    .AW       (AW)
  ) u_mem (
    .CLK     (CLK),
    .WR_EN   (mem_wr_en),
    .WR_ADDR (w_ptr_reg),
    .WR_DATA (DATA),
    .RD_ADDR (r_ptr_reg),
    .RD_DATA (DATA_OUT)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign DATA_READY = !full;
  assign OUT_VALID  = out_valid;
  assign FULL       = full;
  assign EMPTY      = empty;
  assign COUNT      = count_reg;
  assign LINE_DONE  = line_done_reg;

endmodule : line_window_buffer

// File: tb/tb_line_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_window_buffer
//   Directed stimulus for line_window_buffer (PIX_W=8, LINE_LEN=8, WIN=3).
//   Every issued read pushes its hand-computed window into win_q and every
//   last-column read pushes the cycle in which LINE_DONE must be high into
//   ld_q; a negedge monitor pops and compares. Status outputs are checked
//   directly by the stimulus one time unit after the active edge.
// ---------------------------------------------------------------------------
module tb_line_window_buffer;

  localparam int PIX_W    = 8;
  localparam int LINE_LEN = 8;
  localparam int WIN      = 3;

  logic        CLK = 1'b0;
  logic        RESETH = 1'b0;
  logic        CLEAR = 1'b0;
  logic [7:0]  DATA = 8'h00;
  logic        DATA_VALID = 1'b0;
  logic        DATA_READY;
  logic        READ_DATA = 1'b0;
  logic [23:0] DATA_OUT;
  logic        OUT_VALID;
  logic        LINE_DONE;
  logic        FULL;
  logic        EMPTY;
  logic [3:0]  COUNT;

  line_window_buffer #(
    .PIX_W    (PIX_W),
    .LINE_LEN (LINE_LEN),
    .WIN      (WIN)
  ) dut (
    .CLK        (CLK),
    .RESETH     (RESETH),
    .CLEAR      (CLEAR),
    .DATA       (DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .READ_DATA  (READ_DATA),
    .DATA_OUT   (DATA_OUT),
    .OUT_VALID  (OUT_VALID),
    .LINE_DONE  (LINE_DONE),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0] win_q [$];
  int          ld_q  [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: window values on accepted reads, LINE_DONE every cycle.
  always @(negedge CLK) begin
    if (!RESETH) begin
      if (READ_DATA) begin
        if (win_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_unexpected: got READ_DATA with no expected window (t=%0t)", $time);
        end else begin
          logic [23:0] exp_win;
          exp_win = win_q.pop_front();
          check("out_valid_at_read", {31'd0, OUT_VALID}, 32'd1);
          check("window", {8'd0, DATA_OUT}, {8'd0, exp_win});
        end
      end
      begin
        logic exp_ld;
        exp_ld = (ld_q.size() > 0) && (ld_q[0] == cyc);
        n_checks++;
        if (LINE_DONE !== exp_ld) begin
          n_fail++;
          $display("FAIL line_done: got %0b, expected %0b (cyc=%0d)", LINE_DONE, exp_ld, cyc);
        end
        if (exp_ld) void'(ld_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                      input logic [23:0] win, input bit last, input bit clr);
    DATA_VALID = wr;
    DATA       = d;
    READ_DATA  = rd;
    CLEAR      = clr;
    if (rd)   win_q.push_back(win);
    if (last) ld_q.push_back(cyc + 1);
    tick();
    DATA_VALID = 1'b0;
    READ_DATA  = 1'b0;
    CLEAR      = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [23:0] win, input bit last);
    step(1'b0, 8'h00, 1'b1, win, last, 1'b0);
  endtask

  function automatic logic [23:0] win3(input logic [7:0] a);
    return {a, a + 8'd1, a + 8'd2};
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state
    #2 RESETH = 1'b1;
    #20;
    check("rst_count",      {28'd0, COUNT}, 32'd0);
    check("rst_empty",      {31'd0, EMPTY}, 32'd1);
    check("rst_full",       {31'd0, FULL}, 32'd0);
    check("rst_data_ready", {31'd0, DATA_READY}, 32'd1);
    check("rst_out_valid",  {31'd0, OUT_VALID}, 32'd0);
    check("rst_line_done",  {31'd0, LINE_DONE}, 32'd0);
    RESETH = 1'b0;
    tick();

    // First window appears after the third write
    wr(8'h10);
    check("w1_count", {28'd0, COUNT}, 32'd1);
    check("w1_out_valid", {31'd0, OUT_VALID}, 32'd0);
    wr(8'h11);
    check("w2_out_valid", {31'd0, OUT_VALID}, 32'd0);
    wr(8'h12);
    check("w3_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("w3_count", {28'd0, COUNT}, 32'd3);
    check("w3_data_out", {8'd0, DATA_OUT}, 32'h00101112);

    // Fill to FULL, then a write that must be dropped
    for (int i = 3; i < 8; i++) wr(8'h10 + 8'(i));
    check("full_count", {28'd0, COUNT}, 32'd8);
    check("full_flag", {31'd0, FULL}, 32'd1);
    check("full_ready", {31'd0, DATA_READY}, 32'd0);
    check("full_empty", {31'd0, EMPTY}, 32'd0);
    wr(8'h99);
    check("drop_count", {28'd0, COUNT}, 32'd8);
    check("drop_full", {31'd0, FULL}, 32'd1);

    // Drain one line: 6 windows, last one releases 3 pixels
    for (int i = 0; i < 6; i++) rd(win3(8'h10 + 8'(i)), i == 5);
    check("line_done_pulse", {31'd0, LINE_DONE}, 32'd1);
    check("drain_count", {28'd0, COUNT}, 32'd0);
    check("drain_empty", {31'd0, EMPTY}, 32'd1);
    check("drain_out_valid", {31'd0, OUT_VALID}, 32'd0);
    tick();
    check("line_done_single", {31'd0, LINE_DONE}, 32'd0);

    // Simultaneous write+read: interior keeps COUNT, last column drops by 2
    wr(8'h20); wr(8'h21); wr(8'h22); wr(8'h23);
    check("sim_pre_count", {28'd0, COUNT}, 32'd4);
    step(1'b1, 8'h24, 1'b1, 24'h202122, 1'b0, 1'b0);
    check("sim_mid_count", {28'd0, COUNT}, 32'd4);
    step(1'b1, 8'h25, 1'b1, 24'h212223, 1'b0, 1'b0);
    step(1'b1, 8'h26, 1'b1, 24'h222324, 1'b0, 1'b0);
    step(1'b1, 8'h27, 1'b1, 24'h232425, 1'b0, 1'b0);
    rd(24'h242526, 1'b0);
    check("sim_before_last", {28'd0, COUNT}, 32'd3);
    step(1'b1, 8'h30, 1'b1, 24'h252627, 1'b1, 1'b0);
    check("sim_last_count", {28'd0, COUNT}, 32'd1);

    // Second line: writes run w_ptr through 6,7,0 while windows are read
    for (int i = 1; i < 6; i++) wr(8'h30 + 8'(i));
    check("wrap_count", {28'd0, COUNT}, 32'd6);
    step(1'b1, 8'h36, 1'b1, 24'h303132, 1'b0, 1'b0);
    step(1'b1, 8'h37, 1'b1, 24'h313233, 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b1, 24'h323334, 1'b0, 1'b0);
    check("wrap_mid_count", {28'd0, COUNT}, 32'd6);
    rd(24'h333435, 1'b0);
    rd(24'h343536, 1'b0);
    rd(24'h353637, 1'b1);
    check("wrap_end_count", {28'd0, COUNT}, 32'd1);
    wr(8'h41); wr(8'h42);
    rd(24'h404142, 1'b0);
    check("wrap_next_count", {28'd0, COUNT}, 32'd2);

    // Asynchronous reset pulse between clock edges
    #1 RESETH = 1'b1;
    #1;
    check("async_rst_count", {28'd0, COUNT}, 32'd0);
    check("async_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("async_rst_empty", {31'd0, EMPTY}, 32'd1);
    #1 RESETH = 1'b0;
    tick();
    wr(8'h50); wr(8'h51); wr(8'h52);
    check("post_rst_count", {28'd0, COUNT}, 32'd3);
    rd(24'h505152, 1'b0);

    // CLEAR beats a same-cycle write
    step(1'b1, 8'h60, 1'b0, 24'h0, 1'b0, 1'b1);
    check("clear_count", {28'd0, COUNT}, 32'd0);
    check("clear_empty", {31'd0, EMPTY}, 32'd1);
    check("clear_out_valid", {31'd0, OUT_VALID}, 32'd0);
    wr(8'h70); wr(8'h71); wr(8'h72);
    rd(24'h707172, 1'b0);

    tick();
    tick();
    check("win_q_drained", win_q.size(), 32'd0);
    check("ld_q_drained", ld_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_line_window_buffer
